// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_unit
// Purpose  : Instruction prefetch queue. Issues one word fetch at a time,
//            buffers the returned {pc, inst} pairs in a DEPTH-entry FIFO and
//            hands them to decode through a valid/ready handshake. Execute can
//            redirect the fetch stream, and interrupts/exceptions flush the
//            queue and vector the fetch PC to fixed entry points.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            imem_req/addr       - fetch request and word address (bit 31 = 0)
//            imem_ack/rdata      - fetch response strobe and instruction word
//            inst_valid/inst/inst_pc/inst_ready - issue handshake to decode
//            redir_valid/target  - redirect from execute
//            irq, exc            - interrupt and exception requests
//            trap_taken, epc     - trap entry pulse and return PC
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue_unit #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    input  logic        irq,
    input  logic        exc,
    output logic        trap_taken,
    output logic [31:0] epc
);

    localparam int              c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_CW   = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    // Architectural state
    logic [31:0]     r_fpc_q;
    logic [31:0]     r_req_pc_q;      // pc of the request currently in flight
    logic [31:0]     r_epc_q;
    logic [c_CW-1:0] r_count_q;
    logic [c_AW-1:0] r_rd_ptr_q;
    logic [c_AW-1:0] r_wr_ptr_q;
    logic            r_busy_q;        // one request outstanding
    logic            r_discard_q;     // outstanding response belongs to a flushed path
    logic [31:0]     r_pc_mem  [DEPTH];
    logic [31:0]     r_inst_mem[DEPTH];

    // Event decode; priority exc > irq > redirect
    logic        w_irq_take;
    logic        w_trap;
    logic        w_redir;
    logic        w_flush;
    logic        w_ack;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_epc_d;
    logic [31:0] w_redir_pc;

    assign w_irq_take = irq & ~r_fpc_q[31];    // kernel mode masks interrupts
    assign w_trap     = ~reset & (exc | w_irq_take);
    assign w_redir    = ~reset & redir_valid & ~w_trap;
    assign w_flush    = w_trap | w_redir;

    // A jump may drop to user mode but never raise to kernel mode.
    assign w_redir_pc = {r_fpc_q[31] & redir_target[31], redir_target[30:0]};

    // Responses are only meaningful while a request is outstanding; a stray
    // ack (e.g. for a request issued before reset) is ignored.
    assign w_ack  = imem_ack & r_busy_q;
    assign w_push = w_ack & ~r_discard_q & ~w_flush;

    // No fetch on a flush cycle so the first new-path request uses the new PC.
    assign imem_req  = ~reset & ~r_busy_q & (r_count_q < c_FULL) & ~w_flush;
    assign imem_addr = {1'b0, r_fpc_q[30:0]};

    assign inst_valid = ~reset & (r_count_q != '0) & ~w_flush;
    assign inst       = r_inst_mem[r_rd_ptr_q];
    assign inst_pc    = r_pc_mem[r_rd_ptr_q];
    assign w_pop      = inst_valid & inst_ready;

    assign w_epc_d    = (r_count_q != '0) ? r_pc_mem[r_rd_ptr_q] : r_fpc_q;
    assign trap_taken = w_trap;
    assign epc        = w_trap ? w_epc_d : r_epc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fpc_q     <= RESET_VEC;
            r_req_pc_q  <= '0;
            r_epc_q     <= '0;
            r_count_q   <= '0;
            r_rd_ptr_q  <= '0;
            r_wr_ptr_q  <= '0;
            r_busy_q    <= 1'b0;
            r_discard_q <= 1'b0;
        end else begin
            // Fetch PC
            if (w_trap) begin
                r_fpc_q <= exc ? EXC_VEC : IRQ_VEC;
                r_epc_q <= w_epc_d;
            end else if (w_redir) begin
                r_fpc_q <= w_redir_pc;
            end else if (imem_req) begin
                r_fpc_q <= r_fpc_q + 32'd4;
            end

            if (imem_req) begin
                r_req_pc_q <= r_fpc_q;
            end

            // Outstanding-request tracking. A flush coinciding with the ack
            // needs no discard: that response is simply not pushed.
            if (imem_req) begin
                r_busy_q <= 1'b1;
            end else if (w_ack) begin
                r_busy_q <= 1'b0;
            end

            if (w_ack) begin
                r_discard_q <= 1'b0;
            end else if (w_flush && r_busy_q) begin
                r_discard_q <= 1'b1;
            end

            // Queue pointers and occupancy
            if (w_flush) begin
                r_count_q  <= '0;
                r_rd_ptr_q <= '0;
                r_wr_ptr_q <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr_q <= r_wr_ptr_q + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr_q <= r_rd_ptr_q + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count_q <= r_count_q + 1'b1;
                    2'b01:   r_count_q <= r_count_q - 1'b1;
                    default: r_count_q <= r_count_q;
                endcase
            end
        end
    end

    // Queue storage needs no reset; entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr_q]   <= r_req_pc_q;
            r_inst_mem[r_wr_ptr_q] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue_unit
// Purpose  : Directed self-checking bench for fetch_queue_unit. A background
//            memory model answers fetches with inst = addr ^ c_K after a
//            programmable latency; scenario tasks drive control inputs one
//            cycle after the rising edge and check outputs on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_unit;

    localparam logic [31:0] c_K = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_target = '0;
    logic        irq = 1'b0;
    logic        exc = 1'b0;
    logic        trap_taken;
    logic [31:0] epc;

    // Memory model and manual override
    logic        resp_ack = 1'b0;
    logic [31:0] resp_rdata = '0;
    logic [31:0] resp_addr = '0;
    bit          resp_en = 1'b0;
    int          resp_extra = 0;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = '0;

    assign imem_ack   = resp_ack | man_ack;
    assign imem_rdata = man_ack ? man_rdata : resp_rdata;

    int total = 0;
    int bad   = 0;

    fetch_queue_unit #(
        .DEPTH    (4),
        .RESET_VEC(32'h0000_0000),
        .IRQ_VEC  (32'h8000_0004),
        .EXC_VEC  (32'h8000_0008)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redir_valid (redir_valid),
        .redir_target(redir_target),
        .irq         (irq),
        .exc         (exc),
        .trap_taken  (trap_taken),
        .epc         (epc)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (resp_en && imem_req && !reset) begin
                resp_addr = imem_addr;
                @(posedge clk); #1;
                for (int i = 0; i < resp_extra; i++) begin
                    @(posedge clk); #1;
                end
                resp_ack   = 1'b1;
                resp_rdata = resp_addr ^ c_K;
                @(posedge clk); #1;
                resp_ack   = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Leaves the caller one step into the first cycle with reset low.
    task automatic do_reset();
        reset       = 1'b1;
        resp_en     = 1'b0;
        resp_extra  = 0;
        inst_ready  = 1'b0;
        redir_valid = 1'b0;
        irq         = 1'b0;
        exc         = 1'b0;
        man_ack     = 1'b0;
        repeat (6) tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (inst_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
        total++; if (trap_taken !== 1'b0) begin bad++; $display("FAIL rst_trap: got %b want 0", trap_taken); end
        total++; if (epc !== 32'h0) begin bad++; $display("FAIL rst_epc: got %h want 0", epc); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++; $display("FAIL rst_first_req: got req=%b addr=%h want 1/00000000", imem_req, imem_addr); end
    endtask

    task automatic test_streaming();
        int pops = 0;
        int last = 0;
        do_reset();
        resp_en    = 1'b1;
        inst_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (inst_valid && inst_ready) begin
                total++; if (inst_pc !== 32'(pops * 4)) begin
                    bad++; $display("FAIL stream_pc: got %h want %h", inst_pc, 32'(pops * 4)); end
                total++; if (inst !== (32'(pops * 4) ^ c_K)) begin
                    bad++; $display("FAIL stream_inst: got %h want %h", inst, 32'(pops * 4) ^ c_K); end
                if (pops > 0) begin
                    total++; if (c - last != 2) begin
                        bad++; $display("FAIL stream_gap: got %0d want 2", c - last); end
                end
                last = c;
                pops++;
            end
        end
        total++; if (pops != 9) begin bad++; $display("FAIL stream_count: got %0d want 9", pops); end
    endtask

    task automatic test_backpressure();
        int nreq = 0;
        int exp_pc = 0;
        int pops = 0;
        int first_req = -1;
        do_reset();
        resp_en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (imem_req) begin
                total++; if (imem_addr !== 32'(nreq * 4)) begin
                    bad++; $display("FAIL bp_addr: got %h want %h", imem_addr, 32'(nreq * 4)); end
                nreq++;
            end
        end
        total++; if (nreq != 4) begin bad++; $display("FAIL bp_nreq: got %0d want 4", nreq); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_full_req: got %b want 0", imem_req); end
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            bad++; $display("FAIL bp_head: got v=%b pc=%h want 1/00000000", inst_valid, inst_pc); end
        tick();
        inst_ready = 1'b1;
        for (int c = 0; c < 40 && pops < 8; c++) begin
            @(negedge clk);
            if (imem_req && first_req < 0) begin
                first_req = c;
                total++; if (imem_addr !== 32'h10) begin
                    bad++; $display("FAIL bp_resume_addr: got %h want 00000010", imem_addr); end
            end
            if (inst_valid) begin
                total++; if (inst_pc !== 32'(exp_pc)) begin
                    bad++; $display("FAIL bp_drain_pc: got %h want %h", inst_pc, 32'(exp_pc)); end
                exp_pc += 4;
                pops++;
            end
        end
        total++; if (first_req != 1) begin bad++; $display("FAIL bp_resume_cycle: got %0d want 1", first_req); end
        total++; if (pops != 8) begin bad++; $display("FAIL bp_drain_count: got %0d want 8", pops); end
    endtask

    task automatic test_redirect();
        bit found = 1'b0;
        bit ok;
        do_reset();
        resp_en    = 1'b1;
        resp_extra = 2;
        inst_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h10) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (!found) begin bad++; $display("FAIL redir_setup: got no fetch of 00000010 want one"); end
        tick();
        redir_valid  = 1'b1;
        redir_target = 32'h100;
        @(negedge clk);
        total++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
            bad++; $display("FAIL redir_flush_cycle: got v=%b req=%b want 0/0", inst_valid, imem_req); end
        tick();
        redir_valid = 1'b0;
        wait_valid(60, ok);
        total++; if (!ok || inst_pc !== 32'h100) begin
            bad++; $display("FAIL redir_next_pc: got ok=%b pc=%h want 1/00000100", ok, inst_pc); end
        total++; if (inst !== (32'h100 ^ c_K)) begin
            bad++; $display("FAIL redir_next_inst: got %h want %h", inst, 32'h100 ^ c_K); end
        tick();
        wait_valid(60, ok);
        total++; if (!ok || inst_pc !== 32'h104) begin
            bad++; $display("FAIL redir_follow_pc: got ok=%b pc=%h want 1/00000104", ok, inst_pc); end
    endtask

    task automatic test_privilege();
        bit ok;
        // User mode: jump cannot set bit 31.
        do_reset();
        resp_en      = 1'b1;
        inst_ready   = 1'b1;
        redir_valid  = 1'b1;
        redir_target = 32'h0000_0040;
        tick();
        redir_target = 32'h8000_0200;
        tick();
        redir_valid = 1'b0;
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            bad++; $display("FAIL priv_user_addr: got req=%b addr=%h want 1/00000200", imem_req, imem_addr); end
        wait_valid(20, ok);
        total++; if (!ok || inst_pc !== 32'h0000_0200) begin
            bad++; $display("FAIL priv_user_pc: got ok=%b pc=%h want 1/00000200", ok, inst_pc); end
        // Kernel mode reached through an exception, then jumps keep bit 31.
        do_reset();
        inst_ready = 1'b1;
        exc        = 1'b1;
        @(negedge clk);
        total++; if (trap_taken !== 1'b1 || epc !== 32'h0) begin
            bad++; $display("FAIL priv_exc_entry: got trap=%b epc=%h want 1/00000000", trap_taken, epc); end
        tick();
        exc          = 1'b0;
        redir_valid  = 1'b1;
        redir_target = 32'h8000_0010;
        tick();
        redir_target = 32'h8000_0200;
        resp_en      = 1'b1;
        tick();
        redir_valid = 1'b0;
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            bad++; $display("FAIL priv_kern_addr: got req=%b addr=%h want 1/00000200", imem_req, imem_addr); end
        wait_valid(20, ok);
        total++; if (!ok || inst_pc !== 32'h8000_0200) begin
            bad++; $display("FAIL priv_kern_pc: got ok=%b pc=%h want 1/80000200", ok, inst_pc); end
    endtask

    task automatic test_interrupt();
        bit ok;
        do_reset();
        resp_en      = 1'b1;
        redir_valid  = 1'b1;
        redir_target = 32'h20;
        tick();
        redir_valid = 1'b0;
        repeat (12) tick();
        @(negedge clk);
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h20) begin
            bad++; $display("FAIL irq_setup_head: got v=%b pc=%h want 1/00000020", inst_valid, inst_pc); end
        tick();
        irq = 1'b1;
        @(negedge clk);
        total++; if (trap_taken !== 1'b1 || epc !== 32'h20) begin
            bad++; $display("FAIL irq_entry: got trap=%b epc=%h want 1/00000020", trap_taken, epc); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL irq_no_issue: got %b want 0", inst_valid); end
        tick();
        irq = 1'b0;
        @(negedge clk);
        total++; if (trap_taken !== 1'b0 || epc !== 32'h20) begin
            bad++; $display("FAIL irq_pulse_hold: got trap=%b epc=%h want 0/00000020", trap_taken, epc); end
        tick();
        inst_ready = 1'b1;
        wait_valid(20, ok);
        total++; if (!ok || inst_pc !== 32'h8000_0004) begin
            bad++; $display("FAIL irq_vector_pc: got ok=%b pc=%h want 1/80000004", ok, inst_pc); end
        tick();
        inst_ready = 1'b0;
        irq        = 1'b1;
        @(negedge clk);
        total++; if (trap_taken !== 1'b0) begin bad++; $display("FAIL irq_masked: got %b want 0", trap_taken); end
        tick();
        irq = 1'b0;
        wait_valid(20, ok);
        total++; if (!ok || inst_pc !== 32'h8000_0008) begin
            bad++; $display("FAIL irq_masked_stream: got ok=%b pc=%h want 1/80000008", ok, inst_pc); end
    endtask

    task automatic test_stale_ack();
        do_reset();
        @(negedge clk);
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL stale_setup_req: got %b want 1", imem_req); end
        tick();
        reset     = 1'b1;
        exc       = 1'b1;
        man_ack   = 1'b1;
        man_rdata = 32'h1234_5678;
        @(negedge clk);
        total++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || trap_taken !== 1'b0) begin
            bad++; $display("FAIL stale_in_reset: got req=%b v=%b trap=%b want 0/0/0", imem_req, inst_valid, trap_taken); end
        tick();
        reset = 1'b0;
        exc   = 1'b0;
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++; $display("FAIL stale_first_req: got req=%b addr=%h want 1/00000000", imem_req, imem_addr); end
        total++; if (epc !== 32'h0) begin bad++; $display("FAIL stale_epc_reset: got %h want 0", epc); end
        tick();
        man_ack = 1'b0;
        @(negedge clk);
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL stale_dropped: got %b want 0", inst_valid); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        do_reset();
        exc          = 1'b1;
        irq          = 1'b1;
        redir_valid  = 1'b1;
        redir_target = 32'h300;
        @(negedge clk);
        total++; if (trap_taken !== 1'b1 || epc !== 32'h0) begin
            bad++; $display("FAIL simul_entry: got trap=%b epc=%h want 1/00000000", trap_taken, epc); end
        tick();
        exc         = 1'b0;
        irq         = 1'b0;
        redir_valid = 1'b0;
        resp_en     = 1'b1;
        inst_ready  = 1'b1;
        @(negedge clk);
        total++; if (trap_taken !== 1'b0) begin bad++; $display("FAIL simul_one_pulse: got %b want 0", trap_taken); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            bad++; $display("FAIL simul_addr: got req=%b addr=%h want 1/00000008", imem_req, imem_addr); end
        wait_valid(20, ok);
        total++; if (!ok || inst_pc !== 32'h8000_0008) begin
            bad++; $display("FAIL simul_pc: got ok=%b pc=%h want 1/80000008", ok, inst_pc); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect();
        test_privilege();
        test_interrupt();
        test_stale_ack();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4: prefetch queue entries; power of two, 2..16.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000: PC after reset.
REQ-003 SHALL have parameter IRQ_VEC, default 32'h8000_0004: interrupt entry PC.
REQ-004 SHALL have parameter EXC_VEC, default 32'h8000_0008: exception entry PC.
REQ-005 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-007 SHALL have ports imem_req out 1, imem_addr out 32: fetch request and word address, imem_addr[31] always 0.
REQ-008 SHALL have ports imem_ack in 1, imem_rdata in 32: response strobe and instruction word, valid when imem_ack=1.
REQ-009 SHALL have ports inst_valid out 1, inst out 32, inst_pc out 32, inst_ready in 1: issue handshake to decode.
REQ-010 SHALL have ports redir_valid in 1, redir_target in 32: branch/jump/jr redirect from execute.
REQ-011 SHALL have ports irq in 1, exc in 1: interrupt request and exception (illegal op) request.
REQ-012 SHALL have ports trap_taken out 1, epc out 32: one-cycle pulse on IRQ/exception entry, and the return PC.

Function
REQ-013 SHALL hold fetch PC (fpc), a DEPTH-entry FIFO of {pc, inst}, count, and one in-flight flag plus discard flag.
REQ-014 SHALL assert imem_req with imem_addr={1'b0,fpc[30:0]} when no request is in flight and count+1 <= DEPTH; request accepted the same cycle; at most one outstanding.
REQ-015 SHALL advance fpc by 4 (wrap modulo 2^32) in the cycle a request is issued.
REQ-016 SHALL push {request pc, imem_rdata} on imem_ack unless discard flag is set; discarded response clears in-flight and discard flags, pushes nothing.
REQ-017 SHALL drive inst_valid=1 whenever count>0, with inst/inst_pc from the head; pop on inst_valid&inst_ready.
REQ-018 SHALL support push and pop in the same cycle with count unchanged; full queue (count=DEPTH) blocks new requests, never overwrites.
REQ-019 Redirect SHALL flush the queue (count=0), set discard if a request is in flight, and load fpc with target; new fetch begins no earlier than next cycle.
REQ-020 Redirect target bit 31 SHALL be fpc[31] & redir_target[31] (user mode cannot enter kernel by jump).
REQ-021 Priority SHALL be exc > irq > redir_valid; lower-priority events in the same cycle are ignored.
REQ-022 irq SHALL be accepted only when fpc[31]=0 (kernel mode masks interrupts); exc always accepted.
REQ-023 On accepted irq/exc: trap_taken=1 for one cycle, epc = head inst_pc if count>0 else fpc, queue flushed, discard set if in flight, fpc = IRQ_VEC or EXC_VEC.
REQ-024 epc SHALL be combinationally valid with trap_taken and hold its last value otherwise.
REQ-025 No instruction SHALL issue (inst_valid=0) in the cycle a flush occurs.

Reset
REQ-026 On reset=1 at a clock edge: fpc=RESET_VEC, count=0, in-flight=0, discard=0, epc=0.
REQ-027 During reset imem_req=0, inst_valid=0, trap_taken=0; reset mid-transaction SHALL discard any later imem_ack for the pre-reset request.
REQ-028 First request SHALL issue the cycle after reset deasserts, at RESET_VEC.

Verification
REQ-029 Streaming: reset, imem_ack 1 cycle after each req, inst_ready=1 -> inst_pc 0x0,0x4,0x8,... in order, one per 2 cycles, no gaps or duplicates.
REQ-030 Backpressure: inst_ready=0 with DEPTH=4 -> exactly 4 entries fetched (pcs 0x0-0xC), imem_req stays 0 until first pop.
REQ-031 Redirect with request in flight: redir_target=0x100 while fetch of 0x10 outstanding -> 0x10 response dropped, next inst_pc=0x100.
REQ-032 Privilege: fpc=0x0000_0040, redir_target=0x8000_0200 -> next fetch pc 0x0000_0200; from kernel fpc=0x8000_0010 -> 0x8000_0200.
REQ-033 Interrupt: irq with head inst_pc=0x20 -> trap_taken pulse, epc=0x20, next inst_pc=0x8000_0004; irq while fpc[31]=1 -> ignored.
REQ-034 Simultaneous: exc, irq, redir_valid same cycle -> fpc=0x8000_0008, one trap_taken pulse, redirect ignored.
